// File: rtl/ins_loader.sv
// Instruction-memory loader: packs a byte stream into 16-bit words (high byte first)
// and writes them to consecutive addresses from a programmable base, holding the CPU meanwhile.
module ins_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned DATA_W = 2 * BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              count_ok;

  // in_ready_q is only ever set for HI/LO, so it doubles as the transfer qualifier
  assign xfer     = in_valid && in_ready_q;
  assign count_ok = (word_count != '0) && (word_count <= MAX_COUNT);

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_ok) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            state_d     = S_HI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HI: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          hi_d    = in_byte;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wr_addr_d = addr_q;
          wr_data_d = DATA_W'({hi_q, in_byte});
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state they describe
    in_ready_d = (state_d == S_HI) || (state_d == S_LO);
    busy_d     = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WRITE);
    wr_en_d    = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
